// File: rtl/prog_loader_pkg.sv
// Shared definitions for the UART program loader: state encodings,
// default bit period and the header-to-word-count rule.
package prog_loader_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [2:0] {
        L_IDLE  = 3'd0,
        L_HDR   = 3'd1,
        L_HI    = 3'd2,
        L_LO    = 3'd3,
        L_WRITE = 3'd4,
        L_DONE  = 3'd5,
        L_ERR   = 3'd6
    } ld_state_e;

    // A header byte of zero stands for a full 256-word image.
    function automatic logic [8:0] word_count(input logic [7:0] hdr);
        return (hdr == 8'd0) ? 9'd256 : {1'b0, hdr};
    endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, start-bit validation at half
// a bit, data and stop sampled at bit centres. Emits one-cycle strobes.
module uart_rx
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_stb_o,
    output logic       frame_err_stb_o,
    output logic [1:0] state_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    rx_state_e     state_q, state_d;
    logic          sync1_q, sync2_q, prev_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          byte_stb_q, ferr_stb_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= RX_IDLE;
        else         state_q <= state_d;
    end

    // Next state: start on a synchronized falling edge, reject false starts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:  if (!sync2_q && prev_q) state_d = RX_START;
            RX_START: if (cnt_q == HALF_M1) state_d = sync2_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt_q == FULL_M1 && bit_q == 3'd7) state_d = RX_STOP;
            RX_STOP:  if (cnt_q == FULL_M1) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    // Synchronizer, bit timing counter, shift register and strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            byte_stb_q <= 1'b0;
            ferr_stb_q <= 1'b0;
        end else begin
            sync1_q    <= rx_i;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            byte_stb_q <= 1'b0;
            ferr_stb_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    bit_q <= 3'd0;
                end
                RX_START: begin
                    cnt_q <= (cnt_q == HALF_M1) ? '0 : cnt_q + 1'b1;
                    bit_q <= 3'd0;
                end
                RX_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        if (sync2_q) byte_stb_q <= 1'b1;
                        else         ferr_stb_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    assign byte_o          = shift_q;
    assign byte_stb_o      = byte_stb_q;
    assign frame_err_stb_o = ferr_stb_q;
    assign state_o         = state_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a header byte (word count) followed by
// big-endian 16-bit words over UART and writes them to instruction memory.
// dbg_state = {receiver state, loader state} for observation.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        load_en,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        load_done,
    output logic        frame_err,
    output logic [4:0]  dbg_state
);

    logic [7:0] rx_byte;
    logic       rx_byte_stb;
    logic       rx_ferr_stb;
    logic [1:0] rx_state;

    ld_state_e  state_q, state_d;
    logic [8:0] count_q;
    logic [8:0] words_q;
    logic [7:0] addr_q;
    logic [15:0] wdata_q;
    logic       done_q, ferr_q;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .rx_i            (rx),
        .byte_o          (rx_byte),
        .byte_stb_o      (rx_byte_stb),
        .frame_err_stb_o (rx_ferr_stb),
        .state_o         (rx_state)
    );

    // Loader state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= L_IDLE;
        else        state_q <= state_d;
    end

    // Next state; dropping load_en overrides everything, including a write.
    always_comb begin
        state_d = state_q;
        if (!load_en) begin
            state_d = L_IDLE;
        end else begin
            case (state_q)
                L_IDLE:  state_d = L_HDR;
                L_HDR:   if (rx_byte_stb) state_d = L_HI;
                         else if (rx_ferr_stb) state_d = L_ERR;
                L_HI:    if (rx_byte_stb) state_d = L_LO;
                         else if (rx_ferr_stb) state_d = L_ERR;
                L_LO:    if (rx_byte_stb) state_d = L_WRITE;
                         else if (rx_ferr_stb) state_d = L_ERR;
                L_WRITE: state_d = (words_q + 9'd1 == count_q) ? L_DONE : L_HI;
                L_DONE:  state_d = L_DONE;
                L_ERR:   state_d = L_ERR;
                default: state_d = L_IDLE;
            endcase
        end
    end

    // Outputs: write strobe only in L_WRITE, and never during an abort.
    always_comb begin
        mem_we    = (state_q == L_WRITE) && load_en;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        load_done = done_q;
        frame_err = ferr_q;
        dbg_state = {rx_state, state_q};
    end

    // Session datapath: word count, assembly of words, address and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 9'd0;
            words_q <= 9'd0;
            addr_q  <= 8'h00;
            wdata_q <= 16'h0000;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else if (state_q == L_IDLE && state_d == L_HDR) begin
            words_q <= 9'd0;
            addr_q  <= 8'h00;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else if (load_en) begin
            case (state_q)
                L_HDR: begin
                    if (rx_byte_stb)      count_q <= word_count(rx_byte);
                    else if (rx_ferr_stb) ferr_q  <= 1'b1;
                end
                L_HI: begin
                    if (rx_byte_stb)      wdata_q[15:8] <= rx_byte;
                    else if (rx_ferr_stb) ferr_q        <= 1'b1;
                end
                L_LO: begin
                    if (rx_byte_stb)      wdata_q[7:0] <= rx_byte;
                    else if (rx_ferr_stb) ferr_q       <= 1'b1;
                end
                L_WRITE: begin
                    addr_q  <= addr_q + 8'd1;
                    words_q <= words_q + 9'd1;
                    if (state_d == L_DONE) done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed/random bench for prog_loader with a message-level reference model.
module tb_prog_loader;

    localparam int CPB = 8;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic        load_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        load_done;
    logic        frame_err;
    logic [4:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int writes_seen = 0;
    int stb_seen = 0;
    logic prev_we = 1'b0;
    bit abort_arm = 1'b0;
    bit abort_fired = 1'b0;

    logic [23:0] exp_q[$];
    logic [7:0]  msg_q[$];

    prog_loader #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .load_en   (load_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .load_done (load_done),
        .frame_err (frame_err),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // Scoreboard: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                writes_seen++;
                check("we_one_cycle", {31'd0, prev_we}, 32'd0);
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_write: addr=%0h data=%0h, expected no write", mem_addr, mem_wdata);
                end
                if (exp_q.size() > 0) begin
                    logic [23:0] e;
                    e = exp_q.pop_front();
                    check("write", {8'h00, mem_addr, mem_wdata}, {8'h00, e});
                end
            end
            if (dut.rx_byte_stb) stb_seen++;
        end
        prev_we = mem_we;
    end

    // Driver tasks
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) begin
            @(negedge clk);
            if (abort_arm && dut.rx_byte_stb) begin
                load_en = 1'b0;
                abort_arm = 1'b0;
                abort_fired = 1'b1;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        rx = 1'b1;
    endtask

    // Reference model: header N (0 = 256) then big-endian word pairs at
    // consecutive addresses from 0; incomplete or surplus bytes are ignored.
    task automatic model_session();
        int n;
        n = (msg_q[0] == 8'd0) ? 256 : int'(msg_q[0]);
        for (int i = 0; i < n; i++)
            if (2 * i + 2 < msg_q.size())
                exp_q.push_back({8'(i), msg_q[2 * i + 1], msg_q[2 * i + 2]});
    endtask

    task automatic send_msg();
        foreach (msg_q[i]) send_byte(msg_q[i], 1'b1);
    endtask

    task automatic random_msg(input logic [7:0] hdr, input int nbytes);
        msg_q.delete();
        msg_q.push_back(hdr);
        for (int i = 0; i < nbytes; i++) msg_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic start_load();
        load_en = 1'b1;
        wait_cycles(3);
    endtask

    task automatic stop_load();
        load_en = 1'b0;
        wait_cycles(3);
    endtask

    initial begin
        int w0, s0;
        rst_n = 1'b0;
        rx = 1'b1;
        load_en = 1'b0;
        wait_cycles(3);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        check("rst_done", {31'd0, load_done}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        wait_cycles(4);

        // Basic two-word load
        start_load();
        msg_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        model_session();
        check("basic_exp_first", {8'h00, exp_q[0]}, 32'h0000_1234);
        send_msg();
        wait_cycles(4);
        check("basic_drain", exp_q.size(), 32'd0);
        check("basic_done", {31'd0, load_done}, 32'd1);
        check("basic_ferr", {31'd0, frame_err}, 32'd0);
        stop_load();

        // Random short sessions
        for (int k = 0; k < 3; k++) begin
            start_load();
            random_msg(8'($urandom_range(1, 6)), 0);
            for (int i = 0; i < 2 * int'(msg_q[0]); i++) msg_q.push_back(8'($urandom));
            model_session();
            send_msg();
            wait_cycles(4);
            check("rand_drain", exp_q.size(), 32'd0);
            check("rand_done", {31'd0, load_done}, 32'd1);
            stop_load();
        end

        // Full 256-word image plus one surplus byte
        start_load();
        random_msg(8'h00, 513);
        model_session();
        w0 = writes_seen;
        send_msg();
        wait_cycles(4);
        check("full_drain", exp_q.size(), 32'd0);
        check("full_writes", writes_seen - w0, 32'd256);
        check("full_done", {31'd0, load_done}, 32'd1);
        stop_load();

        // Frame error on first data byte
        start_load();
        w0 = writes_seen;
        send_byte(8'h03, 1'b1);
        send_byte(8'h5A, 1'b0);
        wait_cycles(4);
        check("ferr_set", {31'd0, frame_err}, 32'd1);
        check("ferr_done", {31'd0, load_done}, 32'd0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        wait_cycles(4);
        check("ferr_no_writes", writes_seen - w0, 32'd0);
        stop_load();
        start_load();
        check("ferr_cleared", {31'd0, frame_err}, 32'd0);
        stop_load();

        // Short glitch between the high and low byte of a word
        start_load();
        random_msg(8'h01, 2);
        model_session();
        send_byte(msg_q[0], 1'b1);
        send_byte(msg_q[1], 1'b1);
        wait_cycles(2 * CPB);
        s0 = stb_seen;
        rx = 1'b0;
        wait_cycles(CPB / 4);
        rx = 1'b1;
        wait_cycles(3 * CPB);
        check("glitch_no_stb", stb_seen - s0, 32'd0);
        check("glitch_ferr", {31'd0, frame_err}, 32'd0);
        send_byte(msg_q[2], 1'b1);
        wait_cycles(4);
        check("glitch_drain", exp_q.size(), 32'd0);
        check("glitch_done", {31'd0, load_done}, 32'd1);
        stop_load();

        // Abort on the low byte of word 1
        start_load();
        random_msg(8'h02, 4);
        exp_q.push_back({8'h00, msg_q[1], msg_q[2]});
        w0 = writes_seen;
        send_byte(msg_q[0], 1'b1);
        send_byte(msg_q[1], 1'b1);
        send_byte(msg_q[2], 1'b1);
        send_byte(msg_q[3], 1'b1);
        abort_arm = 1'b1;
        send_byte(msg_q[4], 1'b1);
        abort_arm = 1'b0;
        wait_cycles(4);
        check("abort_fired", {31'd0, abort_fired}, 32'd1);
        check("abort_writes", writes_seen - w0, 32'd1);
        check("abort_drain", exp_q.size(), 32'd0);
        check("abort_done", {31'd0, load_done}, 32'd0);

        // Complete a load, then reset asynchronously in the middle of a byte
        start_load();
        msg_q = '{8'h01, 8'h5A, 8'hC3};
        model_session();
        send_msg();
        wait_cycles(4);
        check("pre_rst_done", {31'd0, load_done}, 32'd1);
        check("pre_rst_wdata", {16'd0, mem_wdata}, 32'h5AC3);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we", {31'd0, mem_we}, 32'd0);
        check("arst_addr", {24'd0, mem_addr}, 32'd0);
        check("arst_wdata", {16'd0, mem_wdata}, 32'd0);
        check("arst_done", {31'd0, load_done}, 32'd0);
        check("arst_ferr", {31'd0, frame_err}, 32'd0);
        rx = 1'b1;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(12 * CPB);
        random_msg(8'h01, 2);
        model_session();
        send_msg();
        wait_cycles(4);
        check("post_rst_drain", exp_q.size(), 32'd0);
        check("post_rst_done", {31'd0, load_done}, 32'd1);
        stop_load();

        // Bytes while disabled are ignored; next load starts at address 0
        w0 = writes_seen;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
        wait_cycles(4);
        check("idle_no_writes", writes_seen - w0, 32'd0);
        start_load();
        random_msg(8'h02, 4);
        model_session();
        send_msg();
        wait_cycles(4);
        check("reload_drain", exp_q.size(), 32'd0);
        check("reload_writes", writes_seen - w0, 32'd2);
        check("reload_done", {31'd0, load_done}, 32'd1);
        stop_load();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
